imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time program loader placed upstream of the instruction memory of the monocycle RV64 core.
//   Accepts a framed byte stream (from a UART receiver or testbench) and assembles little-endian 32-bit words.
//   Writes each word into the instruction memory write port.
//   Holds the core in reset until the whole program is written, then releases it.
// PARAMETERS
//   DEPTH    80                  instruction memory depth in 32-bit words; max program length
//   ADDR_W   $clog2(DEPTH)       width of word address on wr_addr
//   MAGIC    8'hA5               frame start byte
// PORTS
//   clk          in   1       system clock, all state on rising edge
//   rst          in   1       asynchronous, active-low reset
//   byte_valid   in   1       byte_data is valid this cycle
//   byte_data    in   8       stream byte
//   byte_ready   out  1       loader accepts byte this cycle (transfer = byte_valid & byte_ready)
//   restart      in   1       1-cycle pulse: leave DONE/ERR, re-hold core, await new frame
//   wr_en        out  1       instruction memory write strobe, 1 cycle per word
//   wr_addr      out  ADDR_W  word index being written (0..N-1)
//   wr_data      out  32      assembled instruction word
//   core_rst_n   out  1       active-low reset to core/PC; 0 while loading
//   done         out  1       program fully written
//   error        out  1       frame rejected (length > DEPTH)
// BEHAVIOUR
//   Frame format: MAGIC, LEN[7:0], LEN[15:8], then 4*LEN bytes; each word is sent LSB first.
//   Reset (rst=0, async): state=IDLE, wr_en=0, wr_addr=0, wr_data=0, byte count=0,
//     core_rst_n=0, done=0, error=0, byte_ready=0 while rst low.
//   byte_ready=1 in IDLE, LEN0, LEN1, DATA; 0 in FIN, DONE, ERR. Outputs are registered.
//   FSM transitions (on a transfer unless noted):
//     IDLE : byte==MAGIC -> LEN0; any other byte is consumed and discarded; stay in IDLE.
//     LEN0 : latch LEN[7:0] -> LEN1.
//     LEN1 : latch LEN[15:8].
//            LEN==0 -> DONE (nothing is written).
//            LEN>DEPTH -> ERR.
//            otherwise -> DATA, word_idx=0, byte_idx=0.
//     DATA : byte goes to wr_data[8*byte_idx +: 8]; byte_idx wraps 3->0.
//            On the 4th byte: wr_en=1 next cycle, wr_addr=word_idx, word_idx++.
//            Last word (word_idx==LEN-1) -> FIN.
//     FIN  : unconditional, 1 cycle (the last wr_en cycle) -> DONE.
//     DONE : done=1, core_rst_n=1; held until restart.
//     ERR  : error=1, core_rst_n=0; no writes; held until restart.
//   Latency: wr_en is asserted in the cycle after the 4th byte transfer. done and core_rst_n
//     rise in the cycle after the final wr_en cycle.
//   wr_en is high for exactly one cycle per word. wr_addr and wr_data stay stable while wr_en=1.
//   Gaps in byte_valid inside a word or frame are allowed; partial bytes are kept with no timeout.
//   restart: honoured only in DONE/ERR. It sets IDLE, core_rst_n=0, done=0, error=0,
//     word_idx=0 and byte_idx=0. It is ignored in any other state.
//   Async reset mid-frame aborts the frame. No further writes occur until a new frame begins.
//     Already-written memory words are left as they are.
//   LEN==DEPTH is legal: it fills addresses 0..DEPTH-1 with no overflow.
//     wr_addr never exceeds DEPTH-1.
// TESTING
//   1. Stream A5,02,00, 13,00,00,00, 93,00,10,00 -> wr_en@addr0=32'h00000013,
//      wr_en@addr1=32'h00100093; done=1 one cycle after the second write.
//   2. Stream 00,FF,A5,01,00, EF,BE,AD,DE with byte_valid toggled every other cycle
//      -> the leading junk is dropped; a single write of addr0=32'hDEADBEEF; done=1.
//   3. Stream A5,51,00 (LEN=81 > DEPTH=80) -> error=1, core_rst_n=0, no wr_en;
//      restart pulse -> IDLE with error=0.
//   4. Stream A5,00,00 -> done=1 and core_rst_n=1 with zero wr_en pulses.
//   5. Stream A5,50,00 plus 320 bytes -> 80 writes at addr 0..79 in order; done=1; no wr_addr >= 80.
//   6. Drop rst low after 6 data bytes of a 2-word frame -> outputs take their reset values at once;
//      a new full frame after release loads correctly starting at addr0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: parses an A5/LEN/words byte stream into imem writes, holds core in reset until done.
// Latency: wr_en one cycle after each word's 4th byte; done/core_rst_n one cycle after last wr_en.
// Backpressure: byte_ready low in FIN/DONE/ERR and during reset; gaps in byte_valid are tolerated.
module imem_loader #(
    parameter int         DEPTH  = 80,
    parameter int         ADDR_W = $clog2(DEPTH),
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    input  logic              restart_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              core_rst_n_o,
    output logic              done_o,
    output logic              error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_FIN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_L = 16'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                core_rst_n_q, core_rst_n_d;

    logic                xfer;
    logic [15:0]         len_full;
    logic [15:0]         word_idx_ext;

    assign xfer         = byte_valid_i & ready_q;
    assign len_full     = {byte_data_i, len_q[7:0]};
    assign word_idx_ext = {{(16-ADDR_W){1'b0}}, word_idx_q};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (xfer && byte_data_i == MAGIC) begin
                    state_d = S_LEN0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = byte_data_i;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d[15:8] = byte_data_i;
                    if (len_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if (len_full > DEPTH_L) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_DATA;
                        word_idx_d = '0;
                        byte_idx_d = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // Assemble in place: the word only changes after its wr_en cycle.
                    wr_data_d[{byte_idx_q, 3'b000} +: 8] = byte_data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_idx_q;
                        word_idx_d = word_idx_q + 1'b1;
                        if (word_idx_ext == len_q - 16'd1) begin
                            state_d = S_FIN;
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_DONE;
            end
            S_DONE, S_ERR: begin
                if (restart_i) begin
                    state_d    = S_IDLE;
                    word_idx_d = '0;
                    byte_idx_d = 2'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        ready_d      = (state_d == S_IDLE) || (state_d == S_LEN0) ||
                       (state_d == S_LEN1) || (state_d == S_DATA);
        done_d       = (state_d == S_DONE);
        core_rst_n_d = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign core_rst_n_o = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random frames checked against a frame-parsing model.
module tb_imem_loader;
    localparam int DEPTH = 80;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          restart;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          core_rst_n;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .MAGIC(8'hA5)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .restart_i    (restart),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .core_rst_n_o (core_rst_n),
        .done_o       (done),
        .error_o      (error)
    );

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          last_wr_cyc, done_rise_cyc, addr_oob, rst_viol;
    logic        done_prev = 1'b0;
    int          got_addr[$];
    logic [31:0] got_data[$];

    logic [7:0]  stream_q[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_status;   // 0 incomplete, 1 done, 2 error

    always @(negedge clk) begin
        cyc++;
        if (wr_en === 1'b1) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(wr_data);
            last_wr_cyc = cyc;
            if (int'(wr_addr) >= DEPTH) addr_oob++;
            if (core_rst_n !== 1'b0) rst_viol++;
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_addr.delete();
        got_data.delete();
        addr_oob      = 0;
        rst_viol      = 0;
        last_wr_cyc   = -1;
        done_rise_cyc = -1;
    endtask

    // Frame semantics: skip to the first magic byte, read LEN, then LEN little-endian words.
    task automatic model_parse();
        int i;
        int len;
        exp_addr.delete();
        exp_data.delete();
        exp_status = 0;
        i = 0;
        while (i < stream_q.size() && stream_q[i] !== 8'hA5) i++;
        if (i + 2 >= stream_q.size()) return;
        len = int'({stream_q[i+2], stream_q[i+1]});
        i += 3;
        if (len == 0) begin exp_status = 1; return; end
        if (len > DEPTH) begin exp_status = 2; return; end
        for (int w = 0; w < len; w++) begin
            if (i + 4*w + 3 >= stream_q.size()) return;
            exp_addr.push_back(w);
            exp_data.push_back({stream_q[i+4*w+3], stream_q[i+4*w+2],
                                stream_q[i+4*w+1], stream_q[i+4*w]});
        end
        exp_status = 1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // gap<0: random 0..-gap idle cycles before each byte; gap>=0: fixed idle cycles.
    task automatic send_stream(input int gap, input int restart_at);
        int t;
        for (int k = 0; k < stream_q.size(); k++) begin
            int g;
            g = (gap < 0) ? $urandom_range(-gap, 0) : gap;
            byte_valid = 1'b0;
            if (k == restart_at) pulse_restart();
            repeat (g) tick();
            byte_valid = 1'b1;
            byte_data  = stream_q[k];
            t = 0;
            while (byte_ready !== 1'b1 && t < 200) begin tick(); t++; end
            if (t >= 200) begin
                total++; bad++;
                $display("FAIL send_timeout byte %0d: byte_ready=%b required 1", k, byte_ready);
                byte_valid = 1'b0;
                return;
            end
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 60 && !(done === 1'b1 || error === 1'b1); i++) tick();
        repeat (3) tick();
    endtask

    task automatic build_frame(input int len, input int junk);
        stream_q.delete();
        for (int j = 0; j < junk; j++) begin
            logic [7:0] b;
            b = 8'($urandom());
            if (b == 8'hA5) b = 8'h5A;
            stream_q.push_back(b);
        end
        stream_q.push_back(8'hA5);
        stream_q.push_back(8'(len));
        stream_q.push_back(8'(len >> 8));
        if (len <= DEPTH)
            for (int j = 0; j < 4*len; j++) stream_q.push_back(8'($urandom()));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; restart = 1'b0;
        #1;
        total++;
        if ({wr_en, wr_addr, wr_data, core_rst_n, done, error, byte_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: wr_en=%b addr=%0d data=%h crst=%b done=%b err=%b rdy=%b required all 0",
                     wr_en, wr_addr, wr_data, core_rst_n, done, error, byte_ready);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (byte_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_idle: byte_ready=%b required 1", byte_ready);
        end
    endtask

    task automatic test_two_words();
        clear_mon();
        stream_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        model_parse();
        send_stream(0, -1);
        wait_end();
        total++;
        if (got_addr.size() != 2) begin
            bad++; $display("FAIL two_words_count: got=%0d required 2", got_addr.size());
        end else begin
            total++;
            if (got_addr[0] != 0 || got_data[0] !== 32'h00000013 ||
                got_addr[1] != 1 || got_data[1] !== 32'h00100093) begin
                bad++;
                $display("FAIL two_words_data: %0d:%h %0d:%h required 0:00000013 1:00100093",
                         got_addr[0], got_data[0], got_addr[1], got_data[1]);
            end
        end
        total++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || done_rise_cyc != last_wr_cyc + 1) begin
            bad++;
            $display("FAIL two_words_done: done=%b crst=%b rise=%0d lastwr=%0d required 1,1,lastwr+1",
                     done, core_rst_n, done_rise_cyc, last_wr_cyc);
        end
        total++;
        if (rst_viol != 0) begin
            bad++; $display("FAIL two_words_core_held: violations=%0d required 0", rst_viol);
        end
        pulse_restart();
        total++;
        if (done !== 1'b0 || core_rst_n !== 1'b0) begin
            bad++; $display("FAIL restart_after_done: done=%b crst=%b required 0,0", done, core_rst_n);
        end
    endtask

    task automatic test_junk_gaps();
        clear_mon();
        stream_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stream(1, -1);
        wait_end();
        total++;
        if (got_addr.size() != 1) begin
            bad++; $display("FAIL junk_count: got=%0d required 1", got_addr.size());
        end else begin
            total++;
            if (got_addr[0] != 0 || got_data[0] !== 32'hDEADBEEF) begin
                bad++; $display("FAIL junk_data: %0d:%h required 0:deadbeef", got_addr[0], got_data[0]);
            end
        end
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL junk_done: done=%b required 1", done);
        end
        pulse_restart();
    endtask

    task automatic test_too_long();
        clear_mon();
        stream_q = '{8'hA5, 8'h51, 8'h00};
        send_stream(0, -1);
        wait_end();
        total++;
        if (error !== 1'b1 || core_rst_n !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL too_long_status: err=%b crst=%b done=%b rdy=%b required 1,0,0,0",
                     error, core_rst_n, done, byte_ready);
        end
        total++;
        if (got_addr.size() != 0) begin
            bad++; $display("FAIL too_long_writes: got=%0d required 0", got_addr.size());
        end
        pulse_restart();
        total++;
        if (error !== 1'b0 || byte_ready !== 1'b1) begin
            bad++; $display("FAIL too_long_restart: err=%b rdy=%b required 0,1", error, byte_ready);
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        stream_q = '{8'hA5, 8'h00, 8'h00};
        send_stream(0, -1);
        wait_end();
        total++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || got_addr.size() != 0) begin
            bad++;
            $display("FAIL zero_len: done=%b crst=%b writes=%0d required 1,1,0",
                     done, core_rst_n, got_addr.size());
        end
        pulse_restart();
    endtask

    task automatic test_full_depth();
        int errs;
        clear_mon();
        build_frame(DEPTH, 0);
        model_parse();
        send_stream(0, -1);
        wait_end();
        total++;
        if (got_addr.size() != DEPTH || addr_oob != 0) begin
            bad++; $display("FAIL full_count: got=%0d oob=%0d required %0d,0", got_addr.size(), addr_oob, DEPTH);
        end
        errs = 0;
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++)
            if (got_addr[k] != exp_addr[k] || got_data[k] !== exp_data[k]) errs++;
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL full_data: word errors=%0d required 0", errs);
        end
        total++;
        if (done !== 1'b1 || done_rise_cyc != last_wr_cyc + 1) begin
            bad++; $display("FAIL full_done: done=%b rise=%0d lastwr=%0d", done, done_rise_cyc, last_wr_cyc);
        end
        pulse_restart();
    endtask

    task automatic test_reset_midframe();
        int pre;
        clear_mon();
        build_frame(2, 0);
        stream_q = stream_q[0:8];
        send_stream(0, -1);
        pre = got_addr.size();
        rst_n = 1'b0;
        #1;
        total++;
        if ({wr_en, wr_addr, wr_data, core_rst_n, done, error, byte_ready} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: wr_en=%b addr=%0d data=%h crst=%b done=%b err=%b rdy=%b required 0",
                     wr_en, wr_addr, wr_data, core_rst_n, done, error, byte_ready);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        total++;
        if (got_addr.size() != pre || pre != 1) begin
            bad++; $display("FAIL midreset_no_writes: writes=%0d before=%0d required 1,1", got_addr.size(), pre);
        end
        clear_mon();
        build_frame(2, 0);
        model_parse();
        send_stream(-1, -1);
        wait_end();
        total++;
        if (got_addr.size() != 2 || got_addr[0] != 0 || got_data[0] !== exp_data[0] ||
            got_addr[1] != 1 || got_data[1] !== exp_data[1] || done !== 1'b1) begin
            bad++; $display("FAIL midreset_reload: writes=%0d done=%b required 2 matching writes, done=1",
                            got_addr.size(), done);
        end
        pulse_restart();
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int r, len, errs;
            r = $urandom_range(9, 0);
            len = (r == 9) ? 81 + $urandom_range(200, 0) : r;
            clear_mon();
            build_frame(len, $urandom_range(3, 0));
            model_parse();
            send_stream(-2, (it == 3 && len > 0 && len <= DEPTH) ? stream_q.size() - 2 : -1);
            wait_end();
            total++;
            if (done !== (exp_status == 1) || error !== (exp_status == 2) ||
                core_rst_n !== (exp_status == 1)) begin
                bad++;
                $display("FAIL rand%0d_status: done=%b err=%b crst=%b required status %0d",
                         it, done, error, core_rst_n, exp_status);
            end
            errs = (got_addr.size() != exp_addr.size()) ? 1 : 0;
            for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++)
                if (got_addr[k] != exp_addr[k] || got_data[k] !== exp_data[k]) errs++;
            total++;
            if (errs != 0 || rst_viol != 0 || addr_oob != 0) begin
                bad++;
                $display("FAIL rand%0d_writes: got=%0d exp=%0d errs=%0d viol=%0d oob=%0d",
                         it, got_addr.size(), exp_addr.size(), errs, rst_viol, addr_oob);
            end
            if (exp_addr.size() > 0) begin
                total++;
                if (done_rise_cyc != last_wr_cyc + 1) begin
                    bad++; $display("FAIL rand%0d_latency: rise=%0d required %0d", it, done_rise_cyc, last_wr_cyc + 1);
                end
            end
            pulse_restart();
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_junk_gaps();
        test_too_long();
        test_zero_len();
        test_full_depth();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
